// File: rtl/fib_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fib_pkg
// Brief    : Shared constants for the Fibonacci checker: the state encoding,
//            the default data width and the term count for 16-bit data.
// Revision : 1.0  initial release
// ============================================================================
package fib_pkg;

  // Checker state encoding
  localparam logic [1:0] HEAD  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] ERROR = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Default sample width
  localparam int FIB_WIDTH = 16;

  // Number of Fibonacci terms (1,1,2,...,46368) that fit in 16 bits
  localparam int FIB_TERMS_16 = 24;

endpackage
`default_nettype wire

// File: rtl/fib_next.sv
`default_nettype none
// ============================================================================
// Module   : fib_next
// Brief    : Registered prev/expected Fibonacci pair. On advance the pair
//            steps forward by one term; the sum is formed one bit wider so
//            the carry out flags the first term that no longer fits.
// Revision : 1.0  initial release
// ============================================================================
module fib_next #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,       // asynchronous, active-low
  input  logic             clear,     // synchronous restart
  input  logic             advance,   // step to the next term
  output logic [WIDTH-1:0] expected,  // current term
  output logic             overflow   // next term does not fit in WIDTH bits
);

  logic [WIDTH-1:0] prev;
  logic [WIDTH:0]   sum;

  // Next term in WIDTH+1 bits; the top bit is the overflow indication
  always_comb begin
    sum      = {1'b0, prev} + {1'b0, expected};
    overflow = sum[WIDTH];
  end

  // Advance the pair; on overflow the pair holds so expected never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev     <= '0;
      expected <= WIDTH'(1);
    end else if (clear) begin
      prev     <= '0;
      expected <= WIDTH'(1);
    end else if (advance && !overflow) begin
      prev     <= expected;
      expected <= sum[WIDTH-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module   : fibonacci_checker
// Brief    : Streaming valid/ready receiver that compares each accepted
//            sample with an internally regenerated Fibonacci term. Reports a
//            per-sample match pulse, a sticky error and a sticky completion
//            flag once the last term that fits in WIDTH bits is accepted.
// Revision : 1.0  initial release
// ============================================================================
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int WIDTH       = FIB_WIDTH,
  parameter int ACCEPT_ZERO = 1,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,         // asynchronous, active-low
  input  logic             clear,       // synchronous restart
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             ok,
  output logic             err,
  output logic             done,
  output logic [CNT_W-1:0] term_count,
  output logic [WIDTH-1:0] expected
);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       accept;
  logic       is_match;
  logic       lead_zero;
  logic       advance;
  logic       mismatch;
  logic       overflow;

  // Handshake and per-sample classification; clear drops a concurrent sample
  always_comb begin
    in_ready  = (state == HEAD) || (state == RUN);
    accept    = in_valid && in_ready && !clear;
    is_match  = (in_data == expected);
    lead_zero = (state == HEAD) && (ACCEPT_ZERO != 0) && (in_data == '0);
    advance   = accept && !lead_zero && is_match;
    mismatch  = accept && !lead_zero && !is_match;
  end

  // Expected-term datapath
  fib_next #(
    .WIDTH (WIDTH)
  ) u_fib_next (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .advance  (advance),
    .expected (expected),
    .overflow (overflow)
  );

  // Next-state selection; ERROR and DONE are only left through clear or rst
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = HEAD;
    end else if (advance) begin
      state_next = overflow ? DONE : RUN;
    end else if (mismatch) begin
      state_next = ERROR;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HEAD;
    end else begin
      state <= state_next;
    end
  end

  // Status flags: ok pulses per good sample, err and done are sticky
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ok   <= 1'b0;
      err  <= 1'b0;
      done <= 1'b0;
    end else if (clear) begin
      ok   <= 1'b0;
      err  <= 1'b0;
      done <= 1'b0;
    end else begin
      ok   <= advance || (accept && lead_zero);
      err  <= err || mismatch;
      done <= done || (advance && overflow);
    end
  end

  // Matched-term counter, leading zeros excluded, saturating at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      term_count <= '0;
    end else if (clear) begin
      term_count <= '0;
    end else if (advance && (term_count != '1)) begin
      term_count <= term_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/fibonacci_checker.md
Name: fibonacci_checker

Overview:
- Streaming receiver and checker for the 16-bit Fibonacci sequence emitted by the fibonacci generator.
- Accepts one sample per valid/ready handshake and compares it against an internally regenerated expected term.
- Reports per-sample match, a sticky mismatch error, and a sticky completion flag once the last term that fits in WIDTH bits has been accepted.
- Sits downstream of the generator as a self-checking monitor, in bench or on-chip.

Parameters:
- WIDTH, 16, data width of samples and expected terms.
- ACCEPT_ZERO, 1, if 1, leading zero samples before the first term are accepted and not counted; if 0, a leading zero is a mismatch.
- CNT_W, 8, width of term_count.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart to the reset state.
- in_valid  in  1  sample present.
- in_data  in  WIDTH  sample value.
- in_ready  out  1  checker can accept; combinational from state.
- ok  out  1  one-cycle pulse, registered: the previous accepted sample matched.
- err  out  1  sticky mismatch flag.
- done  out  1  sticky flag: last representable term accepted.
- term_count  out  CNT_W  number of matched Fibonacci terms, leading zeros excluded.
- expected  out  WIDTH  value the next sample must equal.

Behaviour:
- Async reset (rst=0) forces all of the following immediately, and holds them while low:
  - state=HEAD, prev=0, expected=1, term_count=0, ok=0, err=0, done=0.
- A sample is accepted only when in_valid=1 and in_ready=1. in_ready=1 in HEAD and RUN, 0 in ERROR and DONE.
- HEAD:
  - in_data==0 and ACCEPT_ZERO=1: ok pulses, all else unchanged, stay in HEAD.
  - in_data==expected (1): treat as a RUN match and go to RUN.
  - Any other value: go to ERROR.
- RUN, match (in_data==expected):
  - prev<=expected, expected<=prev+expected, term_count+1, ok=1 next cycle.
  - The sum is formed in WIDTH+1 bits. If bit WIDTH is set, go to DONE, done<=1, and expected holds its current value (no wrap).
- RUN, mismatch: go to ERROR, err<=1, ok=0. expected and term_count freeze at their values at the mismatch.
- ERROR and DONE are absorbing. Samples are ignored (in_ready=0). Exit only via clear or rst.
- clear=1 restores all reset values on the next edge, including err and done.
  - clear beats a simultaneous in_valid; that sample is dropped and not accepted.
- Latency: ok, err, done, term_count and expected all update on the edge that accepts the sample, so they are visible one cycle after accept.
- Back-to-back accepts every cycle are supported.
- Sequence for WIDTH=16: 1,1,2,3,5,...,28657,46368. This gives 24 terms. The accept of 46368 sets done with term_count=24.
- term_count saturates at all-ones and never wraps.
- in_data is ignored when in_valid=0. in_valid with in_ready=0 has no effect.
- err and done are mutually exclusive.

Decomposition:
- Shared package (fib_pkg) holds:
  - State encoding constants: HEAD=2'd0, RUN=2'd1, ERROR=2'd2, DONE=2'd3.
  - Default WIDTH.
  - Constant FIB_TERMS_16=24.
- One natural sub-module, fib_next: registered prev/expected pair with the WIDTH+1-bit adder and overflow flag. It is shared in form with the generator's datapath.
- The FSM, handshake and counters stay in fibonacci_checker.

Test Plan:
1. Reset, then feed 0,0,1,1,2,3,5,8,13 back-to-back.
   - Expect ok pulsed for every accepted sample and err=0.
   - Expect term_count=7 and expected=21 after the last accept.
2. Feed 1,1,2,4.
   - Expect err=1 and in_ready=0 one cycle after 4 is accepted.
   - Expect term_count=3 and expected=3 frozen.
   - Further samples are ignored.
3. Feed the full 24-term sequence up to 46368.
   - Expect done=1, term_count=24, expected=46368 held, in_ready=0.
   - Expect err=0.
4. Set ACCEPT_ZERO=0, reset, feed 0.
   - Expect err=1 and term_count=0.
5. Reach ERROR, then assert clear together with in_valid=1 and in_data=1.
   - Expect reset values on the next cycle and the sample not counted.
   - Then 1,1 gives term_count=2.
6. After 1,1,2 is accepted (term_count=3, expected=3), drop rst asynchronously between clock edges.
   - Expect all outputs at reset values before the next edge.
   - Expect the sequence to restart cleanly after rst is released.
